// File: rtl/digit_scan_driver.sv
// ----------------------------------------------------------------------------
// digit_scan_driver
//   Scans a multiplexed 7-segment display with up to 8 digits, one digit at a
//   time. The driver sends the digit index to an external 8:1 value mux on
//   sel. It decodes the 6-bit code that comes back into active-low segments.
//   It then lights exactly one active-low anode, or none.
//
//   Every digit slot lasts DIV = CLK_HZ/REFRESH_HZ clocks and runs through
//   three phases:
//     BLANK : 1 clock. All anodes are off while the mux settles on the new sel.
//     LOAD  : 1 clock. digit_in is valid. seg, dp and an are registered at
//             the closing edge of this clock.
//     SHOW  : The registered outputs hold until the next prescaler step.
//
// Ports
//   clk         in   1  system clock, rising edge
//   reset       in   1  synchronous, active-high
//   en          in   1  scan enable; low = display dark, scan frozen
//   digit_in    in   6  mux code for the current sel
//   blank_mask  in   8  bit i=1 keeps digit i dark
//   dp_mask     in   8  bit i=1 lights the decimal point of digit i
//   sel         out  3  digit index to the mux
//   an          out  8  anodes, active-low, one-hot-low or all high
//   seg         out  7  {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal point, active-low
//   frame_tick  out  1  one-clock pulse after sel wraps NUM_DIGITS-1 -> 0
// ----------------------------------------------------------------------------
module digit_scan_driver #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1_000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [5:0] digit_in,
    input  logic [7:0] blank_mask,
    input  logic [7:0] dp_mask,
    output logic [2:0] sel,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned DIV   = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
    localparam logic [2:0]       LAST_SEL = 3'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              step;
    logic [2:0]        sel_q;
    logic [7:0]        an_q;
    logic [6:0]        seg_q;
    logic              dp_q;
    logic              frame_tick_q;

    // Map a 6-bit mux code to active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [5:0] code);
        logic [6:0] s;
        case (code)
            6'd0:    s = 7'b1000000;
            6'd1:    s = 7'b1111001;
            6'd2:    s = 7'b0100100;
            6'd3:    s = 7'b0110000;
            6'd4:    s = 7'b0011001;
            6'd5:    s = 7'b0010010;
            6'd6:    s = 7'b0000010;
            6'd7:    s = 7'b1111000;
            6'd8:    s = 7'b0000000;
            6'd9:    s = 7'b0010000;
            6'd10:   s = 7'b0001000;  // A
            6'd11:   s = 7'b0000011;  // b
            6'd12:   s = 7'b1000110;  // C
            6'd13:   s = 7'b0100001;  // d
            6'd14:   s = 7'b0000110;  // E
            6'd15:   s = 7'b0001110;  // F
            6'h3F:   s = SEG_BLANK;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Dwell prescaler. The counter clears while the scan is disabled, so the
    // slot that resumes when en returns gets a full DIV-clock dwell.
    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            step  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Slot sequencer. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            sel_q        <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= 1'b0;
            if (!en) begin
                // Go dark immediately. sel is kept so that the scan resumes
                // on the same digit.
                an_q    <= '1;
                dp_q    <= 1'b1;
                state_q <= ST_BLANK;
            end else begin
                case (state_q)
                    ST_BLANK: begin
                        state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        seg_q   <= decode(digit_in);
                        dp_q    <= ~dp_mask[sel_q];
                        an_q    <= blank_mask[sel_q] ? 8'hFF : ~(8'b1 << sel_q);
                        state_q <= ST_SHOW;
                    end
                    ST_SHOW: begin
                        if (step) begin
                            sel_q        <= (sel_q == LAST_SEL) ? 3'd0 : sel_q + 3'd1;
                            an_q         <= '1;
                            frame_tick_q <= (sel_q == LAST_SEL);
                            state_q      <= ST_BLANK;
                        end
                    end
                    default: begin
                        state_q <= ST_BLANK;
                    end
                endcase
            end
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
